plane_fifo_arbiter: RTL and testbench



---
 rtl/plane_fifo_arbiter_if.sv | 29 ++
 rtl/plane_fifo_arbiter.sv | 96 +++++++++
 tb/tb_plane_fifo_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/plane_fifo_arbiter_if.sv
// Write-port bundle between the two plane producers, the arbiter and the pixel FIFO.
// master = producers/FIFO side, slave = arbiter.
interface plane_fifo_arbiter_if #(
  parameter int DATA_W  = 24,
  parameter int USEDW_W = 10
);
  logic [1:0]         req;
  logic               wr0;
  logic [DATA_W-1:0]  data0;
  logic               wr1;
  logic [DATA_W-1:0]  data1;
  logic [USEDW_W-1:0] wrusedw;
  logic               wrfull;
  logic [1:0]         gnt;
  logic [DATA_W-1:0]  FIFO_data;
  logic               wrreq;
  logic               burst_done;
  logic               overflow;

  modport master (
    output req, wr0, data0, wr1, data1, wrusedw, wrfull,
    input  gnt, FIFO_data, wrreq, burst_done, overflow
  );

  modport slave (
    input  req, wr0, data0, wr1, data1, wrusedw, wrfull,
    output gnt, FIFO_data, wrreq, burst_done, overflow
  );
endinterface

// File: rtl/plane_fifo_arbiter.sv
// Round-robin burst arbiter sharing the VGA pixel FIFO write port between two planes.
// A burst starts only with FIFO headroom and runs for up to BURST_LEN accepted words.
module plane_fifo_arbiter #(
  parameter int DATA_W      = 24,
  parameter int USEDW_W     = 10,
  parameter int FILL_THRESH = 500,
  parameter int BURST_LEN   = 8
) (
  input  logic                clock,
  input  logic                reset,
  plane_fifo_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [USEDW_W-1:0] THRESH    = USEDW_W'(FILL_THRESH);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [0:0]       r_state;
  logic [1:0]       r_gnt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_last_served;
  logic             r_overflow;

  logic              w_sel;
  logic              w_wr_g;
  logic              w_req_g;
  logic [DATA_W-1:0] w_data_g;
  logic              w_wrreq;
  logic              w_burst_end;
  logic              w_headroom;
  logic [1:0]        w_winner;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_sel       = r_gnt[1];
    w_wr_g      = w_sel ? bus.wr1     : bus.wr0;
    w_req_g     = w_sel ? bus.req[1]  : bus.req[0];
    w_data_g    = w_sel ? bus.data1   : bus.data0;
    w_wrreq     = (r_state == ST_GRANT) && w_wr_g && !bus.wrfull;
    // Early release still lets the word presented in the same cycle through.
    w_burst_end = (r_state == ST_GRANT) &&
                  ((w_wrreq && (r_beat_cnt == LAST_BEAT)) || !w_req_g);
    w_headroom  = bus.wrusedw < THRESH;

    w_winner = 2'b00;
    case (bus.req)
      2'b01:   w_winner = 2'b01;
      2'b10:   w_winner = 2'b10;
      2'b11:   w_winner = r_last_served ? 2'b01 : 2'b10;
      default: w_winner = 2'b00;
    endcase
  end

  assign bus.gnt        = r_gnt;
  assign bus.FIFO_data  = (|r_gnt) ? w_data_g : '0;
  assign bus.wrreq      = w_wrreq;
  assign bus.burst_done = w_burst_end;
  assign bus.overflow   = r_overflow;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_gnt         <= 2'b00;
      r_beat_cnt    <= '0;
      r_last_served <= 1'b1;
      r_overflow    <= 1'b0;
    end else begin
      if ((r_state == ST_GRANT) && bus.wrfull && w_wr_g) begin
        r_overflow <= 1'b1;
      end

      if (r_state == ST_IDLE) begin
        if (w_headroom && (|bus.req)) begin
          r_state    <= ST_GRANT;
          r_gnt      <= w_winner;
          r_beat_cnt <= '0;
        end
      end else begin
        if (w_burst_end) begin
          r_state       <= ST_IDLE;
          r_gnt         <= 2'b00;
          r_beat_cnt    <= '0;
          r_last_served <= w_sel;
        end else if (w_wrreq) begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_plane_fifo_arbiter.sv
// Self-checking bench for plane_fifo_arbiter: a cycle-vector table plus directed
// burst, contention, threshold, early-release and async-reset sequences.
module tb_plane_fifo_arbiter;

  logic clock;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  plane_fifo_arbiter_if #(.DATA_W(24), .USEDW_W(10)) bus ();

  plane_fifo_arbiter #(
    .DATA_W(24), .USEDW_W(10), .FILL_THRESH(500), .BURST_LEN(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  req;
    logic        wr0;
    logic [23:0] d0;
    logic        wr1;
    logic [23:0] d1;
    logic [9:0]  usedw;
    logic        full;
    logic [1:0]  e_gnt;
    logic        e_wrreq;
    logic [23:0] e_data;
    logic        e_done;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rq, input logic w0, input logic [23:0] d0,
                       input logic w1, input logic [23:0] d1,
                       input logic [9:0] usedw, input logic full);
    bus.req     = rq;
    bus.wr0     = w0;
    bus.data0   = d0;
    bus.wr1     = w1;
    bus.data1   = d1;
    bus.wrusedw = usedw;
    bus.wrfull  = full;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    drive(2'b00, 1'b0, 24'h0, 1'b0, 24'h0, 10'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Both producers stream continuously; expected grant pattern is an 8-word burst
  // followed by one idle cycle, alternating owners when 'alternate' is set.
  task automatic run_stream(input string tag, input logic [1:0] rq, input bit alternate,
                            input int usedw0, input int usedw1, input int ncyc);
    logic [1:0]  eg;
    logic [23:0] d0, d1, ed;
    int p, b;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      d0 = 24'h0A0000 | 24'(c);
      d1 = 24'h0B0000 | 24'(c);
      drive(rq, 1'b1, d0, 1'b1, d1, (c == 0) ? 10'(usedw0) : 10'(usedw1), 1'b0);
      #1;
      p = (c - 1) % 9;
      b = (c - 1) / 9;
      if (c == 0 || p == 8 || (b > 0 && usedw1 >= 500)) eg = 2'b00;
      else if (alternate && (b % 2 == 1))                eg = 2'b10;
      else                                               eg = 2'b01;
      ed = (eg == 2'b01) ? d0 : (eg == 2'b10) ? d1 : 24'h0;
      check($sformatf("%s gnt c%0d", tag, c), 32'(bus.gnt), 32'(eg));
      check($sformatf("%s wrreq c%0d", tag, c), 32'(bus.wrreq), 32'(eg != 2'b00));
      check($sformatf("%s data c%0d", tag, c), 32'(bus.FIFO_data), 32'(ed));
      check($sformatf("%s done c%0d", tag, c), 32'(bus.burst_done),
            32'((eg != 2'b00) && (p == 7)));
    end
  endtask

  initial begin
    logic [1:0] eg;
    logic [1:0] rq;
    int words1;

    reset = 1'b1;
    drive(2'b00, 1'b0, 24'h0, 1'b0, 24'h0, 10'd0, 1'b0);

    //           req    wr0   d0          wr1   d1          usedw    full  gnt    wrreq data        done  ovf
    vecs[0]  = '{2'b00, 1'b0, 24'h000000, 1'b0, 24'h000000, 10'd0,   1'b0, 2'b00, 1'b0, 24'h000000, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 1'b1, 24'h0000AA, 1'b0, 24'h000000, 10'd500, 1'b0, 2'b00, 1'b0, 24'h000000, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 1'b1, 24'h0000AA, 1'b0, 24'h000000, 10'd500, 1'b0, 2'b00, 1'b0, 24'h000000, 1'b0, 1'b0};
    vecs[3]  = '{2'b01, 1'b1, 24'h000011, 1'b0, 24'h000000, 10'd499, 1'b0, 2'b00, 1'b0, 24'h000000, 1'b0, 1'b0};
    vecs[4]  = '{2'b01, 1'b1, 24'h000001, 1'b0, 24'h000000, 10'd510, 1'b0, 2'b01, 1'b1, 24'h000001, 1'b0, 1'b0};
    vecs[5]  = '{2'b01, 1'b1, 24'h000002, 1'b0, 24'h000000, 10'd510, 1'b1, 2'b01, 1'b0, 24'h000002, 1'b0, 1'b0};
    vecs[6]  = '{2'b01, 1'b0, 24'h000003, 1'b0, 24'h000000, 10'd510, 1'b0, 2'b01, 1'b0, 24'h000003, 1'b0, 1'b1};
    vecs[7]  = '{2'b11, 1'b0, 24'h000003, 1'b1, 24'h000055, 10'd510, 1'b0, 2'b01, 1'b0, 24'h000003, 1'b0, 1'b1};
    vecs[8]  = '{2'b00, 1'b1, 24'h000004, 1'b0, 24'h000055, 10'd0,   1'b0, 2'b01, 1'b1, 24'h000004, 1'b1, 1'b1};
    vecs[9]  = '{2'b00, 1'b0, 24'h000004, 1'b0, 24'h000055, 10'd0,   1'b0, 2'b00, 1'b0, 24'h000000, 1'b0, 1'b1};
    vecs[10] = '{2'b11, 1'b1, 24'h000005, 1'b1, 24'h000055, 10'd0,   1'b0, 2'b00, 1'b0, 24'h000000, 1'b0, 1'b1};
    vecs[11] = '{2'b11, 1'b1, 24'h000006, 1'b1, 24'h000066, 10'd0,   1'b0, 2'b10, 1'b1, 24'h000066, 1'b0, 1'b1};

    #12;
    check("reset gnt", 32'(bus.gnt), 32'h0);
    check("reset wrreq", 32'(bus.wrreq), 32'h0);
    check("reset data", 32'(bus.FIFO_data), 32'h0);
    check("reset done", 32'(bus.burst_done), 32'h0);
    check("reset ovf", 32'(bus.overflow), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      drive(vecs[i].req, vecs[i].wr0, vecs[i].d0, vecs[i].wr1, vecs[i].d1,
            vecs[i].usedw, vecs[i].full);
      #1;
      check($sformatf("vec%0d gnt", i), 32'(bus.gnt), 32'(vecs[i].e_gnt));
      check($sformatf("vec%0d wrreq", i), 32'(bus.wrreq), 32'(vecs[i].e_wrreq));
      check($sformatf("vec%0d data", i), 32'(bus.FIFO_data), 32'(vecs[i].e_data));
      check($sformatf("vec%0d done", i), 32'(bus.burst_done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d ovf", i), 32'(bus.overflow), 32'(vecs[i].e_ovf));
    end

    do_reset();
    run_stream("single", 2'b01, 1'b0, 0, 0, 11);

    do_reset();
    run_stream("contend", 2'b11, 1'b1, 0, 0, 37);

    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      drive(2'b01, 1'b1, 24'h0000EE, 1'b0, 24'h0, 10'd500, 1'b0);
      #1;
      check($sformatf("thresh hold gnt c%0d", c), 32'(bus.gnt), 32'h0);
    end
    run_stream("thresh", 2'b01, 1'b0, 499, 510, 12);

    // Producer 1 releases after 3 accepted words; 4th word goes out in the drop cycle.
    do_reset();
    words1 = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      rq = (c == 13) ? 2'b01 : 2'b11;
      drive(rq, 1'b1, 24'h0A0000 | 24'(c), 1'b1, 24'h0B0000 | 24'(c), 10'd0, 1'b0);
      #1;
      if (c >= 1 && c <= 8)        eg = 2'b01;
      else if (c >= 10 && c <= 13) eg = 2'b10;
      else if (c == 15)            eg = 2'b01;
      else                         eg = 2'b00;
      if (bus.wrreq && bus.gnt == 2'b10) words1++;
      check($sformatf("early gnt c%0d", c), 32'(bus.gnt), 32'(eg));
      check($sformatf("early wrreq c%0d", c), 32'(bus.wrreq), 32'(eg != 2'b00));
      check($sformatf("early done c%0d", c), 32'(bus.burst_done), 32'(c == 8 || c == 13));
    end
    check("early p1 words", 32'(words1), 32'd4);

    // Asynchronous reset lands between edges, right after the 5th word.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      drive(2'b01, 1'b1, 24'h000100 | 24'(c), 1'b0, 24'h0, 10'd0, 1'b0);
      #1;
    end
    check("areset pre gnt", 32'(bus.gnt), 32'h1);
    check("areset pre wrreq", 32'(bus.wrreq), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("areset gnt", 32'(bus.gnt), 32'h0);
    check("areset wrreq", 32'(bus.wrreq), 32'h0);
    check("areset data", 32'(bus.FIFO_data), 32'h0);
    check("areset ovf", 32'(bus.overflow), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    drive(2'b11, 1'b1, 24'h000200, 1'b1, 24'h000300, 10'd0, 1'b0);
    #1;
    check("restart idle gnt", 32'(bus.gnt), 32'h0);
    @(negedge clock);
    #1;
    check("restart first gnt", 32'(bus.gnt), 32'h1);
    check("restart first data", 32'(bus.FIFO_data), 32'h000200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
